// File: rtl/max_pool_2x2_stream.sv
// -----------------------------------------------------------------------------
// max_pool_2x2_stream
//
// Streaming 2x2, stride-2 max-pooling stage for CHANNELS parallel signed
// feature maps arriving in raster order. One input vector is accepted on every
// cycle with i_feature_valid=1 (no backpressure). One pooled vector is produced
// per 2x2 window, one clock after the window's bottom-right pixel is accepted.
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_feature_valid  qualifies i_features for one cycle
//   i_features       input vector, CHANNELS x DATA_W signed
//   o_feature_valid  one-cycle pulse per pooled vector
//   o_features       pooled vector, held between pulses
//
// Build option:
//   MAX_POOL_RELU_EN  when defined, negative pooled results are output as 0.
// -----------------------------------------------------------------------------
module max_pool_2x2_stream #(
  parameter int IN_WIDTH  = 24,
  parameter int IN_HEIGHT = 24,
  parameter int CHANNELS  = 6,
  parameter int DATA_W    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_feature_valid,
  input  logic signed [DATA_W-1:0] i_features [0:CHANNELS-1],
  output logic                     o_feature_valid,
  output logic signed [DATA_W-1:0] o_features [0:CHANNELS-1]
);

  localparam int HALF_W = IN_WIDTH / 2;
  // Keep at least 2 bits so the col/2 slice below is always legal.
  localparam int COL_W  = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 2;
  localparam int ROW_W  = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 2;
  localparam int IDX_W  = COL_W - 1;

  // Position counters
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Per-channel storage
  logic signed [DATA_W-1:0] pair_q [0:CHANNELS-1];
  logic signed [DATA_W-1:0] line_q [0:HALF_W-1][0:CHANNELS-1];
  logic signed [DATA_W-1:0] out_q  [0:CHANNELS-1];
  logic                     valid_q, valid_d;

  // Combinational per-channel results
  logic signed [DATA_W-1:0] h_w   [0:CHANNELS-1];
  logic signed [DATA_W-1:0] res_w [0:CHANNELS-1];

  logic [IDX_W-1:0] lb_idx;
  logic             pair_we;
  logic             lb_we;
  logic             out_we;

  // Pixel pair index within the row doubles as the line-buffer address.
  assign lb_idx = col_q[COL_W-1:1];

  // Even columns start a horizontal pair; odd columns close it. Closing a pair
  // on an even row parks the horizontal max for the row below; on an odd row
  // it completes the 2x2 window.
  always_comb begin
    pair_we = 1'b0;
    lb_we   = 1'b0;
    out_we  = 1'b0;
    if (i_feature_valid) begin
      if (!col_q[0]) begin
        pair_we = 1'b1;
      end else if (!row_q[0]) begin
        lb_we = 1'b1;
      end else begin
        out_we = 1'b1;
      end
    end
    valid_d = out_we;
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_feature_valid) begin
      if (col_q == COL_W'(IN_WIDTH - 1)) begin
        col_d = '0;
        if (row_q == ROW_W'(IN_HEIGHT - 1)) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic signed [DATA_W-1:0] h;
      logic signed [DATA_W-1:0] lb_rd;
      logic signed [DATA_W-1:0] v;

      assign lb_rd = line_q[lb_idx][gi];
      // Signed compares: both operands are declared signed.
      assign h = (i_features[gi] > pair_q[gi]) ? i_features[gi] : pair_q[gi];
      assign v = (h > lb_rd) ? h : lb_rd;
      assign h_w[gi] = h;
`ifdef MAX_POOL_RELU_EN
      assign res_w[gi] = v[DATA_W-1] ? '0 : v;
`else
      assign res_w[gi] = v;
`endif
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        pair_q[ch] <= '0;
        out_q[ch]  <= '0;
      end
      for (int e = 0; e < HALF_W; e++) begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
          line_q[e][ch] <= '0;
        end
      end
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (pair_we) begin
          pair_q[ch] <= i_features[ch];
        end
        if (lb_we) begin
          line_q[lb_idx][ch] <= h_w[ch];
        end
        if (out_we) begin
          out_q[ch] <= res_w[ch];
        end
      end
    end
  end

  assign o_feature_valid = valid_q;
  assign o_features      = out_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// -----------------------------------------------------------------------------
// tb_max_pool_2x2_stream
//
// Directed bench for max_pool_2x2_stream. Frames are generated from simple
// closed-form pixel patterns; expected pooled values come from hand-derived
// closed forms of the same patterns. A negedge monitor checks every pulse
// against a queue of expected (cycle, window) entries filled by the driver.
// -----------------------------------------------------------------------------
module tb_max_pool_2x2_stream;

  localparam int W = 24;
  localparam int H = 24;
  localparam int C = 6;
  localparam int D = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                iv  = 1'b0;
  logic signed [D-1:0] fin  [0:C-1];
  logic signed [D-1:0] fout [0:C-1];
  logic                ov;

  always #5 clk = ~clk;

  max_pool_2x2_stream #(
    .IN_WIDTH (W),
    .IN_HEIGHT(H),
    .CHANNELS (C),
    .DATA_W   (D)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_feature_valid(iv),
    .i_features     (fin),
    .o_feature_valid(ov),
    .o_features     (fout)
  );

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int mode;
    int pr;
    int pc;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // mode 0: column ramp c+k; mode 1: r-c; mode 2: one negative window, rest 0
  function automatic int pix(input int mode, input int r, input int c, input int k);
    case (mode)
      0:       return c + k;
      1:       return r - c;
      default: begin
        if (r == 0 && c == 0) return -5;
        if (r == 0 && c == 1) return -3;
        if (r == 1 && c == 0) return -8;
        if (r == 1 && c == 1) return -128;
        return 0;
      end
    endcase
  endfunction

  function automatic int relu(input int v);
`ifdef MAX_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int exp_pool(input int mode, input int pr, input int pc, input int k);
    int v;
    case (mode)
      0:       v = 2 * pc + 1 + k;
      1:       v = 2 * pr + 1 - 2 * pc;
      default: v = (pr == 0 && pc == 0) ? -3 : 0;
    endcase
    return relu(v);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: each expected window must appear exactly on its cycle.
  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      chk($sformatf("pulse(%0d,%0d)", q[0].pr, q[0].pc), int'(ov), 1);
      for (int k = 0; k < C; k++) begin
        chk($sformatf("m%0d_pool(%0d,%0d)ch%0d", q[0].mode, q[0].pr, q[0].pc, k),
            int'(fout[k]), exp_pool(q[0].mode, q[0].pr, q[0].pc, k));
      end
      if (ov) pulses++;
      void'(q.pop_front());
    end else begin
      chk($sformatf("no_pulse@%0d", cyc), int'(ov), 0);
    end
  end

  task automatic send_pix(input int mode, input int r, input int c);
    @(posedge clk);
    #1;
    iv = 1'b1;
    for (int k = 0; k < C; k++) fin[k] = D'(pix(mode, r, c, k));
    if ((r % 2) == 1 && (c % 2) == 1) q.push_back('{cyc + 1, mode, r / 2, c / 2});
  endtask

  // Idle cycles carry a large value so any use of unqualified data shows up.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      iv = 1'b0;
      for (int k = 0; k < C; k++) fin[k] = 8'sd127;
    end
  endtask

  task automatic send_frame(input int mode, input int gap);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send_pix(mode, r, c);
        if (gap > 0) idle(gap);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < C; k++) fin[k] = '0;

    // Reset state
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rst_valid", int'(ov), 0);
    for (int k = 0; k < C; k++) chk($sformatf("rst_feat%0d", k), int'(fout[k]), 0);
    rst = 1'b0;

    // Column ramp, valid every cycle
    pulses = 0;
    send_frame(0, 0);
    idle(3);
    chk("ramp_pulses", pulses, 144);
    chk("hold_ch0", int'(fout[0]), 23);
    chk("hold_ch5", int'(fout[5]), 28);

    // Asynchronous reset between clock edges
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(ov), 0);
    for (int k = 0; k < C; k++) chk($sformatf("async_rst_feat%0d", k), int'(fout[k]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Signed r-c pattern
    pulses = 0;
    send_frame(1, 0);
    idle(3);
    chk("signed_pulses", pulses, 144);

    // All-negative window {-5,-3,-8,-128}
    pulses = 0;
    send_frame(2, 0);
    idle(3);
    chk("negwin_pulses", pulses, 144);

    // Column ramp with valid pattern 1,0,0
    pulses = 0;
    send_frame(0, 2);
    idle(3);
    chk("bubble_pulses", pulses, 144);

    // Reset mid-frame after 300 valid inputs
    pulses = 0;
    for (int i = 0; i < 300; i++) send_pix(1, i / W, i % W);
    idle(2);
    chk("partial_pulses", pulses, 72);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("partial_queue", q.size(), 0);
    pulses = 0;
    send_frame(0, 0);
    idle(3);
    chk("post_rst_pulses", pulses, 144);

    // Two back-to-back frames, no idle between them
    pulses = 0;
    send_frame(1, 0);
    send_frame(1, 0);
    idle(3);
    chk("b2b_pulses", pulses, 288);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_pool_2x2_stream.md
Name: max_pool_2x2_stream

Overview:
- Streaming 2x2, stride-2 max-pooling stage. It sits between the conv block (6 parallel 24x24 signed feature maps, raster order) and the next layer.
- Consumes one 6-channel feature vector per valid cycle. Emits one 6-channel pooled vector per 2x2 window, giving a 12x12 output map per frame.
- Needs no backpressure: the block always accepts input.

Parameters:
- IN_WIDTH, 24, input map columns per row (must be even).
- IN_HEIGHT, 24, input map rows per frame (must be even).
- CHANNELS, 6, parallel feature channels.
- DATA_W, 8, bits per feature, two's-complement signed.

Ports:
- i_clk  in  1  single system clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_feature_valid  in  1  qualifies i_features for one cycle.
- i_features  in  CHANNELS x DATA_W (unpacked [0:CHANNELS-1], signed)  input feature vector.
- o_feature_valid  out  1  one-cycle pulse marking a pooled vector.
- o_features  out  CHANNELS x DATA_W (unpacked [0:CHANNELS-1], signed)  pooled vector.

Behaviour:
- Reset (async, i_rst=1):
  - col counter, row counter, line buffer, pair register, o_features all clear to 0.
  - o_feature_valid clears to 0.
  - A reset mid-frame discards partial state; the next valid input is treated as pixel (0,0).
- Counting:
  - Counters advance only on cycles with i_feature_valid=1. Gaps of any length are allowed and do not change pooling results.
  - col counts 0..IN_WIDTH-1, then wraps to 0 and increments row.
  - row counts 0..IN_HEIGHT-1, then wraps to 0. The next frame starts with no idle cycle required.
- Per-channel datapath (all comparisons signed; equal values keep either value):
  - Even col: latch input into the pair register.
  - Odd col: h = max(pair register, input).
  - Even row, odd col: write h into line buffer entry col/2. The line buffer holds IN_WIDTH/2 x CHANNELS x DATA_W.
  - Odd row, odd col: result = max(h, line buffer[col/2]).
  - Register result into o_features and assert o_feature_valid on the next clock edge (latency 1 cycle after the accepted input).
- Output timing:
  - o_feature_valid is high for exactly one cycle per window.
  - Exactly (IN_WIDTH/2)*(IN_HEIGHT/2) = 144 pulses per frame, in raster order of the pooled map.
  - o_features holds its last value while o_feature_valid=0.
- No overflow is possible: outputs equal one of the inputs, at the same width.
- Line buffer reads/writes are in the same cycle at the same address only on different row parities, so there are no read/write hazards. Distributed RAM or registers are acceptable.

Optional Feature:
- Macro MAX_POOL_RELU_EN.
- When defined, each channel's pooled result is clamped: a negative result is output as 0, non-negative results pass unchanged. Latency is unchanged.
- When undefined, the signed max passes through unmodified.

Test Plan:
- Reset: i_rst=1 for 20 cycles -> o_feature_valid=0 and all o_features=0. Asserting i_rst asynchronously between clock edges clears them immediately.
- Column ramp: every channel k fed value c+k at (r,c), one frame, valid every cycle.
  - Expect 144 pulses.
  - Pooled (pr,pc) channel k = 2*pc+1+k.
  - First pulse 1 cycle after input (1,1); last pulse 1 cycle after input (23,23).
- Signed data: input (r - c) on all channels, macro off -> pooled (pr,pc) = 2*pr+1-2*pc (e.g. (0,11) = -21). All-negative window {-5,-3,-8,-128} -> -3.
- Bubbles: same column ramp with i_feature_valid toggling 1,0,0,1,... -> identical 144 output values. Pulses occur only 1 cycle after qualifying odd/odd inputs.
- Reset mid-frame: after 300 valid inputs assert i_rst for 2 cycles, then send a full frame -> exactly 144 pulses with correct values; no stale line-buffer data leaks.
- Back-to-back frames plus ReLU: two frames with no gap, macro defined, input (r - c) -> 288 pulses. Pooled (0,11) = 0; pooled (11,0) = 23.
